// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 binary32 constants, operand classes, the
// divide/sqrt FSM states and the special-operand decode for FDIV_S / FSQRT_S.
package fpu_pkg;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
    localparam int          FP_EXP_BIAS  = 127;
    localparam int          FP_MANT_W    = 23;
    localparam int          FP_EXP_W     = 8;

    // fflags = {NV, DZ, OF, UF, NX}
    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp_class_t;

    typedef enum logic [2:0] {IDLE, PREP, ITER, RND, FIN} fsm_state_e;

    typedef struct packed {
        logic        hit;
        logic [31:0] res;
        logic [4:0]  flags;
    } fp_special_t;

    // Subnormals classify as ZERO: the unit flushes them.
    function automatic fp_class_t fp_classify(input logic [31:0] x);
        if (x[30:23] == 8'h00) return ZERO;
        if (x[30:23] != 8'hFF) return NORM;
        if (x[22:0] == 23'd0)  return INF;
        return x[22] ? QNAN : SNAN;
    endfunction

    function automatic fp_special_t fp_div_sqrt_special(input logic op,
                                                        input logic [31:0] a,
                                                        input logic [31:0] b);
        fp_special_t s;
        fp_class_t   ca;
        fp_class_t   cb;
        logic        sgn;
        ca      = fp_classify(a);
        cb      = fp_classify(b);
        sgn     = a[31] ^ b[31];
        s.hit   = 1'b1;
        s.res   = FP_CANON_NAN;
        s.flags = 5'd0;
        if (!op) begin
            if (ca == QNAN || ca == SNAN || cb == QNAN || cb == SNAN)
                s.flags[FFLAG_NV] = (ca == SNAN) || (cb == SNAN);
            else if ((ca == ZERO && cb == ZERO) || (ca == INF && cb == INF))
                s.flags[FFLAG_NV] = 1'b1;
            else if (ca == INF)
                s.res = {sgn, 8'hFF, 23'd0};
            else if (ca == ZERO || cb == INF)
                s.res = {sgn, 31'd0};
            else if (cb == ZERO) begin
                s.res             = {sgn, 8'hFF, 23'd0};
                s.flags[FFLAG_DZ] = 1'b1;
            end else
                s.hit = 1'b0;
        end else begin
            if (ca == QNAN || ca == SNAN)
                s.flags[FFLAG_NV] = (ca == SNAN);
            else if (ca == ZERO)
                s.res = {a[31], 31'd0};
            else if (a[31])
                s.flags[FFLAG_NV] = 1'b1;
            else if (ca == INF)
                s.res = {1'b0, 8'hFF, 23'd0};
            else
                s.hit = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational normalize (at most one left shift), round-to-nearest-even and
// exponent range check with flush-to-zero; shared by the FPU result paths.
module fp_round_rne
    import fpu_pkg::*;
(
    input  logic              sign_i,
    input  logic signed [9:0] exp_i,
    input  logic [25:0]       mant_i,
    input  logic              sticky_i,
    output logic [31:0]       result_o,
    output logic [4:0]        fflags_o
);

    logic [23:0]       mant_n;
    logic [24:0]       mant_r;
    logic              guard;
    logic              rnd;
    logic              inc;
    logic              inexact;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;

    always_comb begin
        if (mant_i[25]) begin
            mant_n = mant_i[25:2];
            guard  = mant_i[1];
            rnd    = mant_i[0];
            exp_n  = exp_i;
        end else begin
            // The bits below the shifted-out round position live in the sticky term.
            mant_n = mant_i[24:1];
            guard  = mant_i[0];
            rnd    = 1'b0;
            exp_n  = exp_i - 10'sd1;
        end
        inexact  = guard | rnd | sticky_i;
        inc      = guard & (rnd | sticky_i | mant_n[0]);
        mant_r   = {1'b0, mant_n} + {24'd0, inc};
        exp_r    = exp_n + $signed({9'd0, mant_r[24]});
        fflags_o = 5'd0;
        result_o = {sign_i, exp_r[7:0], (mant_r[24] ? mant_r[23:1] : mant_r[22:0])};
        if (exp_r >= 10'sd255) begin
            result_o           = {sign_i, 8'hFF, 23'd0};
            fflags_o[FFLAG_OF] = 1'b1;
            fflags_o[FFLAG_NX] = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            result_o           = {sign_i, 31'd0};
            fflags_o[FFLAG_UF] = 1'b1;
            fflags_o[FFLAG_NX] = 1'b1;
        end else begin
            fflags_o[FFLAG_NX] = inexact;
        end
    end

endmodule

// File: rtl/fp_div_sqrt_iter.sv
// Iterative binary32 FDIV_S / FSQRT_S unit, radix-2 restoring, one bit per cycle.
// Optional FP_DIV_EARLY_SPECIAL_EN: specials and divide-by-±1.0 finish one cycle after start.
module fp_div_sqrt_iter
    import fpu_pkg::*;
#(
    parameter int width = 32,
    parameter int ITERS = 26
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic             kill,
    input  logic [width-1:0] dataA,
    input  logic [width-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] result,
    output logic [4:0]       fflags
);

    localparam logic [4:0] CNT_LAST = 5'(ITERS - 1);

    fsm_state_e        state_q, state_d;
    logic              op_q, sign_q, done_q;
    logic [31:0]       a_q, b_q, stage_res_q, result_q;
    logic [4:0]        stage_flags_q, fflags_q, cnt_q;
    logic signed [9:0] exp_q;
    logic [25:0]       quo_q;
    logic [27:0]       rem_q;
    logic [51:0]       rad_q;
    logic [23:0]       divisor_q;

    fp_special_t       spec_prep, early;
    logic [23:0]       ma, mb;
    logic signed [9:0] exp_div, exp_unb, exp_sqrt;
    logic [51:0]       rad_init;
    logic              div_ge, sqrt_ge, bit_d;
    logic [27:0]       sqrt_rem_sh, sqrt_trial, rem_d;
    logic [31:0]       rnd_res;
    logic [4:0]        rnd_flags;

    always_comb begin
        spec_prep = fp_div_sqrt_special(op_q, a_q, b_q);
        ma        = {1'b1, a_q[22:0]};
        mb        = {1'b1, b_q[22:0]};
        exp_div   = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
        exp_unb   = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        exp_sqrt  = (exp_unb >>> 1) + 10'sd127;
        // Odd unbiased exponent: radicand becomes 2*m so the root exponent halves exactly.
        rad_init  = exp_unb[0] ? {ma, 1'b0, 27'd0} : {1'b0, ma, 27'd0};

        div_ge      = rem_q >= {4'd0, divisor_q};
        sqrt_rem_sh = {rem_q[25:0], rad_q[51:50]};
        sqrt_trial  = {quo_q, 2'b01};
        sqrt_ge     = sqrt_rem_sh >= sqrt_trial;
        bit_d       = op_q ? sqrt_ge : div_ge;
        if (op_q)
            rem_d = sqrt_ge ? (sqrt_rem_sh - sqrt_trial) : sqrt_rem_sh;
        else
            rem_d = div_ge ? ((rem_q - {4'd0, divisor_q}) << 1) : (rem_q << 1);
    end

`ifdef FP_DIV_EARLY_SPECIAL_EN
    always_comb begin
        early = fp_div_sqrt_special(op, dataA, dataB);
        if (!early.hit && !op && dataB[30:0] == {8'd127, 23'd0}) begin
            early.hit   = 1'b1;
            early.res   = {dataA[31] ^ dataB[31], dataA[30:0]};
            early.flags = 5'd0;
        end
    end
`else
    assign early = '0;
`endif

    fp_round_rne u_round (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .mant_i   (quo_q),
        .sticky_i (|rem_q),
        .result_o (rnd_res),
        .fflags_o (rnd_flags)
    );

    always_comb begin
        state_d = state_q;
        if (kill)
            state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    if (start) state_d = early.hit ? FIN : PREP;
                PREP:    state_d = spec_prep.hit ? FIN : ITER;
                ITER:    if (cnt_q == CNT_LAST) state_d = RND;
                RND:     state_d = FIN;
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            op_q          <= 1'b0;
            sign_q        <= 1'b0;
            done_q        <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            stage_res_q   <= '0;
            stage_flags_q <= '0;
            result_q      <= '0;
            fflags_q      <= '0;
            cnt_q         <= '0;
            exp_q         <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            rad_q         <= '0;
            divisor_q     <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FIN) && !kill;
            if (!kill) begin
                case (state_q)
                    IDLE: if (start) begin
                        op_q          <= op;
                        a_q           <= dataA;
                        b_q           <= dataB;
                        stage_res_q   <= early.res;
                        stage_flags_q <= early.flags;
                    end
                    PREP: begin
                        cnt_q         <= '0;
                        quo_q         <= '0;
                        divisor_q     <= mb;
                        stage_res_q   <= spec_prep.res;
                        stage_flags_q <= spec_prep.flags;
                        sign_q        <= op_q ? 1'b0 : (a_q[31] ^ b_q[31]);
                        exp_q         <= op_q ? exp_sqrt : exp_div;
                        rem_q         <= op_q ? 28'd0 : {4'd0, ma};
                        rad_q         <= op_q ? rad_init : 52'd0;
                    end
                    ITER: begin
                        cnt_q <= (cnt_q == CNT_LAST) ? 5'd0 : cnt_q + 5'd1;
                        quo_q <= {quo_q[24:0], bit_d};
                        rem_q <= rem_d;
                        rad_q <= rad_q << 2;
                    end
                    RND: begin
                        stage_res_q   <= rnd_res;
                        stage_flags_q <= rnd_flags;
                    end
                    FIN: begin
                        result_q <= stage_res_q;
                        fflags_q <= stage_flags_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign fflags = fflags_q;

endmodule

// File: tb/tb_fp_div_sqrt_iter.sv
// Directed bench for fp_div_sqrt_iter: results, flags, latency, kill, reset and
// ignored start; expected values are hand-computed binary32 constants.
module tb_fp_div_sqrt_iter;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        op      = 1'b0;
    logic        kill    = 1'b0;
    logic [31:0] dataA   = 32'd0;
    logic [31:0] dataB   = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  fflags;

    int n_tests = 0;
    int n_fail  = 0;

    fp_div_sqrt_iter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .kill    (kill),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .fflags  (fflags)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one operation at the next edge (edge 0) and waits for done.
    // glitch_at >= 0 pulses an extra start while busy, which must be ignored.
    task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic [4:0] exp_fl, input int exp_lat, input int glitch_at);
        int   edge_n;
        logic busy_ok;
        op     = o;
        dataA  = a;
        dataB  = b;
        start  = 1'b1;
        tick();
        start   = 1'b0;
        edge_n  = 0;
        busy_ok = 1'b1;
        check({tag, "/done_low_after_start"}, {31'd0, done}, 32'd0);
        while (done !== 1'b1 && edge_n < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (edge_n == glitch_at) begin
                start = 1'b1;
                op    = ~o;
                dataA = 32'h40800000;
                dataB = 32'h3F800000;
            end
            tick();
            start = 1'b0;
            edge_n++;
        end
        check({tag, "/done"},    {31'd0, done}, 32'd1);
        check({tag, "/latency"}, edge_n, exp_lat);
        check({tag, "/busy_held"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "/busy_low"},  {31'd0, busy}, 32'd0);
        check({tag, "/result"},  result, exp_res);
        check({tag, "/fflags"},  {27'd0, fflags}, {27'd0, exp_fl});
        $display("[TB] %s op=%0d a=%h b=%h -> result=%h fflags=%b latency=%0d",
                 tag, o, a, b, result, fflags, edge_n);
    endtask

    initial begin
        logic seen_done;

        #12;
        check("reset/busy",   {31'd0, busy}, 32'd0);
        check("reset/done",   {31'd0, done}, 32'd0);
        check("reset/result", result, 32'd0);
        check("reset/fflags", {27'd0, fflags}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        tick();

        // Back-to-back: each call starts in the cycle right after the previous done.
        run_op("div_6_2",  1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29, -1);
        run_op("div_1_3",  1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29, -1);
        run_op("sqrt_2",   1'b1, 32'h40000000, 32'h00000000, 32'h3FB504F3, 5'b00001, 29, -1);
        tick();
        run_op("div_1_0",  1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2, -1);
        run_op("sqrt_m4",  1'b1, 32'hC0800000, 32'h00000000, 32'h7FC00000, 5'b10000, 2, -1);
        run_op("div_of",   1'b0, 32'h7F000000, 32'h00800000, 32'h7F800000, 5'b00101, 29, -1);
        tick();

        // Kill: raised after edge 10, sampled at edge 11.
        op    = 1'b0;
        dataA = 32'h3F800000;
        dataB = 32'h40400000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("kill/busy_before", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill/busy_after", {31'd0, busy}, 32'd0);
        check("kill/done",       {31'd0, done}, 32'd0);
        check("kill/result",     result, 32'h7F800000);
        check("kill/fflags",     {27'd0, fflags}, {27'd0, 5'b00101});
        seen_done = 1'b0;
        repeat (30) begin
            tick();
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("kill/no_done", {31'd0, seen_done}, 32'd0);
        $display("[TB] kill at edge 11 -> busy=%0d result=%h", busy, result);

        run_op("div_uf",     1'b0, 32'h00800000, 32'h7F000000, 32'h00000000, 5'b00011, 29, -1);
        tick();
        run_op("div_glitch", 1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29, 5);
        tick();

        // kill and start together in IDLE: start is dropped.
        op    = 1'b1;
        dataA = 32'h40800000;
        start = 1'b1;
        kill  = 1'b1;
        tick();
        start = 1'b0;
        kill  = 1'b0;
        check("kill_start/busy", {31'd0, busy}, 32'd0);
        $display("[TB] start+kill in IDLE -> busy=%0d", busy);

        // Asynchronous reset in the middle of ITER.
        op    = 1'b0;
        dataA = 32'h40C00000;
        dataB = 32'h40000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("rst_mid/busy_before", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid/busy",   {31'd0, busy}, 32'd0);
        check("rst_mid/done",   {31'd0, done}, 32'd0);
        check("rst_mid/result", result, 32'd0);
        check("rst_mid/fflags", {27'd0, fflags}, 32'd0);
        $display("[TB] reset mid-ITER -> busy=%0d result=%h fflags=%b", busy, result, fflags);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        run_op("sqrt_4",   1'b1, 32'h40800000, 32'h00000000, 32'h40000000, 5'b00000, 29, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_div_sqrt_iter.md
Name: fp_div_sqrt_iter

Overview:
Iterative single-precision divider and square-root unit that produces the FDIV_S and FSQRT_S results, the multi-cycle inverse operations of the FPU's combinational multiplier path. It sits beside the FPU in EX. The pipeline issues an operation with a start pulse, stalls while busy is high, and captures the result on a one-cycle done pulse. It uses radix-2 restoring iteration on the mantissa, round-to-nearest-even only, and flush-to-zero for subnormals.

Parameters:
width, 32, operand/result width; only 32 (IEEE-754 binary32) is supported
ITERS, 26, mantissa iterations (24 result bits + guard + round; sticky comes from the final remainder)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  1  0 = divide (dataA/dataB), 1 = sqrt(dataA)
kill  input  1  pipeline flush; abort the current operation
dataA  input  width  dividend / radicand
dataB  input  width  divisor (ignored for sqrt)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; result valid
result  output  width  rounded result, held until the next done
fflags  output  5  {NV,DZ,OF,UF,NX}, valid with done

Behaviour:
- Reset (async, reset_n low): state=IDLE, busy=0, done=0, result=0, fflags=0, iteration counter=0.
- States and transitions:
  - IDLE: start=1 latches op/dataA/dataB and moves to PREP.
  - PREP: unpack operands; classify each as zero/inf/NaN/normal, with subnormal treated as signed zero. A special case loads its result and goes to FIN. Otherwise go to ITER:
    - divide: exponent = eA-eB+127.
    - sqrt: exponent = (eA-127)>>1 + 127, with the mantissa pre-shifted left 1 when eA-127 is odd.
  - ITER: one quotient/root bit per cycle. Counter runs 0..ITERS-1, then go to RND.
  - RND: normalize by at most one left shift, round RNE using guard/round/sticky (sticky = remainder != 0), handle mantissa carry-out, check exponent range. Go to FIN.
  - FIN: done=1 for this cycle only, then return to IDLE.
- Latency, counting the edge that accepts start as edge 0:
  - normal operands: done high after edge 29 (PREP 1 + ITER 26 + RND 1 + FIN 1).
  - special cases: done high after edge 2.
- busy=1 in PREP, ITER, RND, FIN; busy=0 in IDLE.
- start while busy is ignored, with no queueing.
- start and done in the same cycle: impossible by construction, because start is sampled only in IDLE.
- kill: the state is IDLE at the next edge, with no done pulse. result and fflags keep their previous values. kill in IDLE has no effect. kill has priority over start in the same cycle.
- Divide special cases:
  - any NaN → 0x7FC00000, NV if sNaN.
  - 0/0 or inf/inf → 0x7FC00000, NV.
  - x/0 (x finite nonzero) → signed inf, DZ.
  - inf/x → signed inf.
  - 0/x or x/inf → signed zero.
- Sqrt special cases:
  - NaN → 0x7FC00000, NV if sNaN.
  - negative nonzero (including -inf) → 0x7FC00000, NV.
  - ±0 → ±0.
  - +inf → +inf.
- Divide result sign = signA ^ signB.
- Range after rounding:
  - exponent ≥ 255 → signed inf, OF|NX.
  - exponent ≤ 0 → signed zero, UF|NX (flush-to-zero).
  - otherwise NX = guard|round|sticky.

Optional Feature:
- Macro: FP_DIV_EARLY_SPECIAL_EN.
- Defined:
  - special-case operands skip PREP→FIN and set done after edge 1.
  - start with dataB exponent = 127 and mantissa = 0 (divide by ±1.0) also completes after edge 1, with result = dataA with sign adjusted; subnormal dataA still flushes.
- Undefined: behaviour exactly as above (2-cycle specials, full iteration for ±1.0 divisors).

Decomposition:
- Shared package fpu_pkg holds:
  - constants: FP_CANON_NAN = 32'h7FC00000, FP_EXP_BIAS = 127, FP_MANT_W = 23, FP_EXP_W = 8, fflags bit indices.
  - typedef fp_class_t {ZERO, NORM, INF, QNAN, SNAN}.
  - state enum {IDLE, PREP, ITER, RND, FIN}.
- One sub-module, fp_round_rne: combinational normalize/round/range-check, reusable by the FPU's FADD/FMUL paths.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) → result 0x40400000, fflags 0, done exactly after edge 29, busy high edges 1–29.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB, NX=1; sqrt 0x40000000 → 0x3FB504F3, NX=1.
- 0x3F800000 / 0x00000000 → 0x7F800000, DZ=1 after edge 2; sqrt 0xC0800000 (-4.0) → 0x7FC00000, NV=1.
- 0x7F000000 / 0x00800000 → 0x7F800000, OF|NX; 0x00800000 / 0x7F000000 → 0x00000000, UF|NX.
- kill asserted at edge 10 of a divide → IDLE at edge 11, no done, result unchanged. A start pulse during busy is ignored. reset_n low mid-ITER → all outputs 0 immediately.
- Back-to-back: start reasserted in the cycle after done → second operation accepted, correct result with the same latency.
